// File: rtl/lsu_pkg.sv
// Shared constants for the MEM-stage load/store path: RV32I funct3 access
// encodings and the byte-enable width of the data memory.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned BE_WIDTH = 4;

endpackage

// File: rtl/load_store_unit.sv
// Combinational load/store steering: byte enables and lane-replicated write
// data for stores, lane selection and sign/zero extension for loads.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic [31:0]         address,
  input  logic [31:0]         store_data,
  input  logic [2:0]          funct3,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic [31:0]         load_data,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_write_data,
  output logic [BE_WIDTH-1:0] mem_byte_enable,
  output logic                mem_enable,
  output logic                mem_we,
  input  logic [31:0]         mem_read_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign mem_address = {address[31:2], 2'b00};
  assign mem_enable  = mem_read | mem_write;
  assign mem_we      = mem_write;

  // Store path: misaligned SH/SW simply drop the low address bits.
  always_comb begin
    mem_byte_enable = '0;
    mem_write_data  = store_data;
    if (mem_write) begin
      case (funct3)
        F3_B: begin
          mem_byte_enable = 4'b0001 << address[1:0];
          mem_write_data  = {4{store_data[7:0]}};
        end
        F3_H: begin
          mem_byte_enable = address[1] ? 4'b1100 : 4'b0011;
          mem_write_data  = {2{store_data[15:0]}};
        end
        F3_W: begin
          mem_byte_enable = 4'b1111;
          mem_write_data  = store_data;
        end
        default: begin
          mem_byte_enable = '0;
          mem_write_data  = store_data;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (address[1:0])
      2'd0: w_byte = mem_read_data[7:0];
      2'd1: w_byte = mem_read_data[15:8];
      2'd2: w_byte = mem_read_data[23:16];
      2'd3: w_byte = mem_read_data[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = address[1] ? mem_read_data[31:16] : mem_read_data[15:0];
  end

  always_comb begin
    load_data = '0;
    if (mem_read) begin
      case (funct3)
        F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
        F3_H:    load_data = {{16{w_half[15]}}, w_half};
        F3_W:    load_data = mem_read_data;
        F3_BU:   load_data = {24'h000000, w_byte};
        F3_HU:   load_data = {16'h0000, w_half};
        default: load_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/simple_memory.sv
// Byte-enabled data memory: synchronous write, combinational read, and a
// synchronous reset that clears every word and overrides any write.
module simple_memory
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  write_enable,
  input  logic [BE_WIDTH-1:0]   byte_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data
);

  localparam int unsigned Depth = 2 ** (ADDR_WIDTH - 2);

  logic [31:0]           r_mem [Depth];
  logic [ADDR_WIDTH-3:0] w_index;
  logic                  w_unused_addr;

  assign w_index       = address[ADDR_WIDTH-1:2];
  assign w_unused_addr = ^address[1:0];
  assign read_data     = enable ? r_mem[w_index] : 32'h0000_0000;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (enable && write_enable) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (byte_enable[b]) begin
          r_mem[w_index][8*b +: 8] <= write_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/lsu_mem_subsystem.sv
// MEM-stage data-memory subsystem: load/store unit in front of a byte-enabled
// memory; loads resolve combinationally, stores commit on the rising edge.
module lsu_mem_subsystem
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] load_data,
  output logic [31:0] mem_address
);

  logic [31:0]         w_mem_address;
  logic [31:0]         w_mem_write_data;
  logic [31:0]         w_mem_read_data;
  logic [BE_WIDTH-1:0] w_mem_byte_enable;
  logic                w_mem_enable;
  logic                w_mem_we;

  assign mem_address = w_mem_address;

  load_store_unit u_lsu (
    .address         (address),
    .store_data      (store_data),
    .funct3          (funct3),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .load_data       (load_data),
    .mem_address     (w_mem_address),
    .mem_write_data  (w_mem_write_data),
    .mem_byte_enable (w_mem_byte_enable),
    .mem_enable      (w_mem_enable),
    .mem_we          (w_mem_we),
    .mem_read_data   (w_mem_read_data)
  );

  simple_memory #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock        (clock),
    .reset        (reset),
    .enable       (w_mem_enable),
    .write_enable (w_mem_we),
    .byte_enable  (w_mem_byte_enable),
    .address      (w_mem_address[ADDR_WIDTH-1:0]),
    .write_data   (w_mem_write_data),
    .read_data    (w_mem_read_data)
  );

endmodule

// File: tb/tb_lsu_mem_subsystem.sv
// Bench for lsu_mem_subsystem: directed plan vectors plus random traffic,
// checked against a byte-array reference model of the data memory.
module tb_lsu_mem_subsystem;

  logic        clock;
  logic        reset;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] load_data;
  logic [31:0] mem_address;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [7:0] m_mem [4096];

  lsu_mem_subsystem #(
    .ADDR_WIDTH (12)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .store_data  (store_data),
    .funct3      (funct3),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .load_data   (load_data),
    .mem_address (mem_address)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3,
                                             input logic rd);
    int unsigned bi, hi, wi;
    logic [15:0] h;
    bi = int'(a[11:0]);
    hi = int'(a[11:1]) * 2;
    wi = int'(a[11:2]) * 4;
    h  = {m_mem[hi+1], m_mem[hi]};
    if (!rd) return 32'h0;
    case (f3)
      3'b000:  return 32'($signed(m_mem[bi]));
      3'b001:  return 32'($signed(h));
      3'b010:  return {m_mem[wi+3], m_mem[wi+2], m_mem[wi+1], m_mem[wi]};
      3'b100:  return 32'(m_mem[bi]);
      3'b101:  return 32'(h);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [2:0] f3);
    int unsigned bi, hi, wi;
    bi = int'(a[11:0]);
    hi = int'(a[11:1]) * 2;
    wi = int'(a[11:2]) * 4;
    case (f3)
      3'b000: m_mem[bi] = d[7:0];
      3'b001: begin
        m_mem[hi]   = d[7:0];
        m_mem[hi+1] = d[15:8];
      end
      3'b010: for (int k = 0; k < 4; k++) m_mem[wi+k] = d[8*k +: 8];
      default: ;
    endcase
  endfunction

  // Read strobe is held high during stores to exercise read-before-write.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    @(negedge clock);
    address    = a;
    store_data = d;
    funct3     = f3;
    mem_write  = 1'b1;
    mem_read   = 1'b1;
    #1;
    check("read_during_write", load_data, model_load(a, f3, 1'b1));
    @(posedge clock);
    model_store(a, d, f3);
    #1;
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic rd);
    @(negedge clock);
    address  = a;
    funct3   = f3;
    mem_read = rd;
    #1;
    check(tag, load_data, model_load(a, f3, rd));
    check({tag, "_maddr"}, mem_address, {a[31:2], 2'b00});
    mem_read = 1'b0;
  endtask

  task automatic do_load_exp(input string tag, input logic [31:0] a, input logic [2:0] f3,
                             input logic [31:0] exp);
    do_load(tag, a, f3, 1'b1);
    address  = a;
    funct3   = f3;
    mem_read = 1'b1;
    #1;
    check({tag, "_const"}, load_data, exp);
    mem_read = 1'b0;
  endtask

  // Reset edge with an SW to the given address deliberately held active.
  task automatic do_reset(input logic [31:0] a);
    @(negedge clock);
    reset      = 1'b1;
    address    = a;
    store_data = 32'h7777_7777;
    funct3     = 3'b010;
    mem_write  = 1'b1;
    @(posedge clock);
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    #1;
    reset     = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'h1, 32'h0);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] a, hi_bits;
    int unsigned op;
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b0;
    address    = '0;
    store_data = '0;
    funct3     = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 8'h00;

    do_reset(32'h0000_0000);
    do_load_exp("reset_lw0", 32'h000, 3'b010, 32'h0);
    do_load_exp("reset_lb7", 32'h7ff, 3'b000, 32'h0);

    do_store(32'h000, 32'hDEADBEEF, 3'b010);
    do_load_exp("lw_000", 32'h000, 3'b010, 32'hDEADBEEF);
    do_store(32'h004, 32'h12345678, 3'b010);
    do_load_exp("lw_004", 32'h004, 3'b010, 32'h12345678);

    do_store(32'h100, 32'h0, 3'b010);
    do_store(32'h100, 32'h000000AA, 3'b000);
    do_store(32'h101, 32'h000000BB, 3'b000);
    do_store(32'h102, 32'h000000CC, 3'b000);
    do_store(32'h103, 32'h000000DD, 3'b000);
    do_load_exp("sb_merge", 32'h100, 3'b010, 32'hDDCCBBAA);
    do_store(32'h200, 32'h00001234, 3'b001);
    do_store(32'h202, 32'h00005678, 3'b001);
    do_load_exp("sh_merge", 32'h200, 3'b010, 32'h56781234);

    do_store(32'h300, 32'h8899AABB, 3'b010);
    do_load_exp("lb_300", 32'h300, 3'b000, 32'hFFFFFFBB);
    do_load_exp("lb_301", 32'h301, 3'b000, 32'hFFFFFFAA);
    do_load_exp("lb_302", 32'h302, 3'b000, 32'hFFFFFF99);
    do_load_exp("lb_303", 32'h303, 3'b000, 32'hFFFFFF88);
    do_load_exp("lh_300", 32'h300, 3'b001, 32'hFFFFAABB);
    do_load_exp("lh_302", 32'h302, 3'b001, 32'hFFFF8899);
    do_store(32'h304, 32'h01020304, 3'b010);
    do_load_exp("lb_304", 32'h304, 3'b000, 32'h00000004);

    do_store(32'h400, 32'hFFEEDDCC, 3'b010);
    do_load_exp("lbu_400", 32'h400, 3'b100, 32'h000000CC);
    do_load_exp("lbu_401", 32'h401, 3'b100, 32'h000000DD);
    do_load_exp("lbu_402", 32'h402, 3'b100, 32'h000000EE);
    do_load_exp("lbu_403", 32'h403, 3'b100, 32'h000000FF);
    do_load_exp("lhu_400", 32'h400, 3'b101, 32'h0000DDCC);
    do_load_exp("lhu_402", 32'h402, 3'b101, 32'h0000FFEE);
    do_load_exp("lh_misalign", 32'h401, 3'b001, 32'hFFFFDDCC);

    do_load("align_901", 32'h901, 3'b010, 1'b1);
    do_load("align_A03", 32'hA03, 3'b010, 1'b1);
    do_load("no_read", 32'h000, 3'b010, 1'b0);
    do_store(32'h000, 32'h55555555, 3'b011);
    do_load_exp("bad_f3_store", 32'h000, 3'b010, 32'hDEADBEEF);
    do_load_exp("bad_f3_load", 32'h000, 3'b011, 32'h0);
    do_load_exp("alias_hi", 32'hFFFF_F000, 3'b010, 32'hDEADBEEF);

    do_reset(32'h000);
    do_load_exp("post_reset_lw0", 32'h000, 3'b010, 32'h0);
    do_load_exp("post_reset_lw300", 32'h300, 3'b010, 32'h0);
    do_load_exp("post_reset_lb400", 32'h403, 3'b000, 32'h0);

    for (int it = 0; it < 600; it++) begin
      hi_bits = $urandom();
      a = ($urandom_range(0, 3) == 0) ? (hi_bits & 32'hFFFF_F000) : 32'h0;
      a = a | 32'($urandom_range(0, 63));
      op = $urandom_range(0, 39);
      if (op < 14)      do_store(a, $urandom(), 3'($urandom_range(0, 2)));
      else if (op < 17) do_store(a, $urandom(), 3'($urandom_range(3, 7)));
      else if (op < 36) do_load("rnd_load", a, 3'($urandom_range(0, 7)), 1'b1);
      else if (op < 39) do_load("rnd_noread", a, 3'($urandom_range(0, 7)), 1'b0);
      else begin
        do_reset(a);
        do_load("rnd_post_reset", a, 3'b010, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
